cache_ctl: RTL and testbench
============================

CACHE_CTL -- requirements
Module: cache_ctl

Interface
- REQ-001 The block SHALL have parameter LINES, default 16, number of direct-mapped lines; power of 2, 2..256.
- REQ-002 The block SHALL have parameter WORDS, default 4, 32-bit words per line; power of 2, 1..16.
- REQ-003 The block SHALL derive OFS=log2(WORDS), IDX=log2(LINES) and TAGW=30-IDX-OFS from the parameters; the block SHALL NOT expose these as parameters.
- REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
- REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-006 Port MemRead, input, 1 bit: CPU read request.
- REQ-007 Port MemWrite, input, 1 bit: CPU write request.
- REQ-008 Port memAddr, input, 32 bits: CPU byte address; bits [1:0] SHALL be ignored.
- REQ-009 Port memWriteData, input, 32 bits: CPU write data.
- REQ-010 Port flush, input, 1 bit: invalidate-all request.
- REQ-011 Port memReadData, output, 32 bits: CPU read data.
- REQ-012 Port MemReadDone, output, 1 bit: read data valid this cycle.
- REQ-013 Port MemHit, output, 1 bit: the current read is a hit.
- REQ-014 Port stall, output, 1 bit: the CPU SHALL hold its request and address while stall is high.
- REQ-015 Port busReq, output, 1 bit: memory-side request.
- REQ-016 Port busWe, output, 1 bit: memory-side write enable.
- REQ-017 Port busAddr, output, 32 bits: memory-side word-aligned address.
- REQ-018 Port busWData, output, 32 bits: memory-side write data.
- REQ-019 Port busRData, input, 32 bits: memory-side read data.
- REQ-020 Port MemReadReady, input, 1 bit: memory-side acknowledge; busRData is valid when it is high during a read.
- REQ-021 Port hitCount, output, 16 bits: saturating read-hit counter.
- REQ-022 Port missCount, output, 16 bits: saturating read-miss counter.

Function
- REQ-023 Address split SHALL be: tag=memAddr[31:32-TAGW], index=memAddr[IDX+OFS+1:OFS+2], word=memAddr[OFS+1:2].
- REQ-024 The FSM SHALL have exactly the states IDLE, FILL, DONE and WRITE.
- REQ-025 Read hit in IDLE (valid[index] and tag match): MemHit=1, MemReadDone=1 and memReadData=stored word, all combinationally in the same cycle; stall=0; state remains IDLE; hitCount increments.
- REQ-026 Read miss in IDLE: stall=1 combinationally in that cycle; missCount increments; next state is FILL with beat=0.
- REQ-027 FILL: busReq=1, busWe=0, busAddr={tag,index,beat,2'b00}; each cycle with MemReadReady=1 the block SHALL write busRData into word[beat] and increment beat; stall=1 throughout FILL.
- REQ-028 On the acknowledged last beat (beat=WORDS-1): set valid[index], store the tag, and go to DONE.
- REQ-029 DONE (exactly 1 cycle): MemReadDone=1, MemHit=0, memReadData=requested word from a register, stall=0; then IDLE.
- REQ-030 Write in IDLE (write-through, no write-allocate): go to WRITE; stall=1 from the request cycle until acknowledge.
- REQ-031 WRITE: busReq=1, busWe=1, busAddr={memAddr[31:2],2'b00}, busWData=memWriteData, held until MemReadReady=1.
- REQ-032 On the WRITE acknowledge cycle: if the line is a hit, update the cached word; stall=0 in that cycle; next state IDLE.
- REQ-033 On a write miss, cache contents SHALL be unchanged.
- REQ-034 MemRead and MemWrite both high SHALL be treated as a write only.
- REQ-035 Neither MemRead nor MemWrite high: no state change, stall=0, MemReadDone=0.
- REQ-036 flush high in IDLE SHALL clear all valid bits at that clock edge; a request in the same cycle is serviced against the pre-flush contents.
- REQ-037 flush high in FILL, DONE or WRITE SHALL set a pending flag; the invalidation SHALL occur on the first edge in IDLE, including a line just filled.
- REQ-038 Counters SHALL saturate at 16'hFFFF and never wrap.
- REQ-039 busReq SHALL be 0 in IDLE and DONE; MemReadReady outside FILL and WRITE SHALL be ignored.
- REQ-040 Data and tag arrays need not be reset; only valid bits, FSM, beat, pending-flush flag, counters and output registers are reset.

Reset
- REQ-041 reset low SHALL immediately, without a clock: state=IDLE; beat=0; all valid=0; pending-flush=0; hitCount=missCount=0; busReq=busWe=0; MemReadDone=MemHit=stall=0; memReadData=0.
- REQ-042 Reset asserted mid-FILL or mid-WRITE SHALL abort the transaction; after release the first read of that line SHALL miss.
- REQ-043 Leaving reset SHALL take effect on the first rising clk edge after reset goes high.

Verification
- REQ-044 Cold read: LINES=16, WORDS=4, read 0x100 with 1-cycle-latency memory -> stall for 4 beats at bus addresses 0x100/104/108/10C, DONE returns word 0, missCount=1.
- REQ-045 Warm read: then read 0x108 -> same-cycle MemHit=1, MemReadDone=1, data = beat 2, hitCount=1, busReq stays 0.
- REQ-046 Write hit: write 0x104 <- 0xDEADBEEF, ack after 3 cycles -> stall 3 cycles with busWe=1; a later read of 0x104 hits and returns 0xDEADBEEF.
- REQ-047 Conflict: read 0x100 then 0x500 (same index, different tag) -> second read misses; re-read 0x100 misses.
- REQ-048 Flush during FILL: flush pulses at beat 1 -> fill completes and DONE returns data; next read of the same address misses.
- REQ-049 Reset mid-FILL at beat 2 -> all outputs 0 asynchronously; re-read misses and refills from beat 0; preload hitCount=0xFFFF then hit -> stays 0xFFFF.

Source files
------------

// File: rtl/cache_ctl.sv
// cache_ctl: direct-mapped, write-through / no-write-allocate cache controller.
// Ports:
//   clk, reset (async, active-low)
//   CPU side : MemRead, MemWrite, memAddr, memWriteData, flush ->
//              memReadData, MemReadDone, MemHit, stall
//   Bus side : busReq, busWe, busAddr, busWData -> busRData, MemReadReady
//   Stats    : hitCount, missCount (saturating read hit/miss counters)
// Read hits complete combinationally in IDLE; misses burst-fill the whole line
// (FILL) and return the requested word from a register (DONE). Writes always go
// to the bus (WRITE) and update the cached word only on a hit.
module cache_ctl #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] memAddr,
  input  logic [31:0] memWriteData,
  input  logic        flush,
  output logic [31:0] memReadData,
  output logic        MemReadDone,
  output logic        MemHit,
  output logic        stall,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  input  logic [31:0] busRData,
  input  logic        MemReadReady,
  output logic [15:0] hitCount,
  output logic [15:0] missCount
);

  localparam int unsigned OFS  = $clog2(WORDS);
  localparam int unsigned IDX  = $clog2(LINES);
  localparam int unsigned TAGW = 30 - IDX - OFS;
  localparam int unsigned BW   = (OFS > 0) ? OFS : 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE, WRITE} state_t;

  state_t            state, next_state;
  logic [BW-1:0]     beat;
  logic [LINES-1:0]  valid;
  logic              flush_pend;
  logic [31:0]       rdata_q;
  logic [TAGW-1:0]   tag_mem  [LINES];
  logic [31:0]       data_mem [LINES][WORDS];

  // Address fields of the current CPU request
  logic [TAGW-1:0]   tag_c;
  logic [IDX-1:0]    idx_c;
  logic [BW-1:0]     word_c;
  logic              hit_c, rd_hit_c, rd_miss_c, last_c;
  logic [31:0]       fill_addr_c;
  logic              unused_addr_bits;

  assign tag_c       = memAddr[31:32-TAGW];
  assign idx_c       = memAddr[IDX+OFS+1:OFS+2];
  assign word_c      = BW'(memAddr[31:2] & 30'(WORDS - 1));
  assign hit_c       = valid[idx_c] && (tag_mem[idx_c] == tag_c);
  assign rd_hit_c    = (state == IDLE) && MemRead && !MemWrite && hit_c;
  assign rd_miss_c   = (state == IDLE) && MemRead && !MemWrite && !hit_c;
  assign last_c      = (beat == BW'(WORDS - 1));
  assign fill_addr_c = (32'(memAddr[31:OFS+2]) << (OFS + 2)) | (32'(beat) << 2);
  assign unused_addr_bits = ^memAddr[1:0];

  // Next state and CPU/bus outputs; all forced low while reset is asserted
  always_comb begin
    next_state  = state;
    memReadData = '0;
    MemReadDone = 1'b0;
    MemHit      = 1'b0;
    stall       = 1'b0;
    busReq      = 1'b0;
    busWe       = 1'b0;
    busAddr     = '0;
    busWData    = '0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (MemWrite) begin
            stall      = 1'b1;
            next_state = WRITE;
          end else if (MemRead) begin
            if (hit_c) begin
              MemHit      = 1'b1;
              MemReadDone = 1'b1;
              memReadData = data_mem[idx_c][word_c];
            end else begin
              stall      = 1'b1;
              next_state = FILL;
            end
          end
        end
        FILL: begin
          busReq  = 1'b1;
          busAddr = fill_addr_c;
          stall   = 1'b1;
          if (MemReadReady && last_c) next_state = DONE;
        end
        DONE: begin
          MemReadDone = 1'b1;
          memReadData = rdata_q;
          next_state  = IDLE;
        end
        WRITE: begin
          busReq   = 1'b1;
          busWe    = 1'b1;
          busAddr  = {memAddr[31:2], 2'b00};
          busWData = memWriteData;
          stall    = !MemReadReady;
          if (MemReadReady) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Control state, valid bits, deferred flush and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat       <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
      rdata_q    <= '0;
      hitCount   <= '0;
      missCount  <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          beat       <= '0;
          flush_pend <= 1'b0;
          if (flush || flush_pend) valid <= '0;
          if (rd_hit_c && (hitCount != 16'hFFFF)) hitCount <= hitCount + 16'd1;
          if (rd_miss_c && (missCount != 16'hFFFF)) missCount <= missCount + 16'd1;
        end
        FILL: begin
          if (flush) flush_pend <= 1'b1;
          if (MemReadReady) begin
            beat <= beat + BW'(1);
            if (beat == word_c) rdata_q <= busRData;
            if (last_c) valid[idx_c] <= 1'b1;
          end
        end
        default: begin
          if (flush) flush_pend <= 1'b1;
        end
      endcase
    end
  end

  // Tag and data arrays (not reset; guarded by valid bits)
  always_ff @(posedge clk) begin
    if (state == FILL && MemReadReady) begin
      data_mem[idx_c][beat] <= busRData;
      if (last_c) tag_mem[idx_c] <= tag_c;
    end else if (state == WRITE && MemReadReady && hit_c) begin
      data_mem[idx_c][word_c] <= memWriteData;
    end
  end

endmodule

// File: tb/tb_cache_ctl.sv
module tb_cache_ctl;

  localparam int unsigned LINES = 16;
  localparam int unsigned WORDS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, flush, MemReadReady;
  logic [31:0] memAddr, memWriteData, busRData;
  logic [31:0] memReadData, busAddr, busWData;
  logic        MemReadDone, MemHit, stall, busReq, busWe;
  logic [15:0] hitCount, missCount;

  cache_ctl #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .memAddr(memAddr),
    .memWriteData(memWriteData), .flush(flush),
    .memReadData(memReadData), .MemReadDone(MemReadDone), .MemHit(MemHit),
    .stall(stall), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
    .busWData(busWData), .busRData(busRData), .MemReadReady(MemReadReady),
    .hitCount(hitCount), .missCount(missCount)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: backing memory plus which line base address occupies each index.
  // Write-through keeps cached data equal to memory, so hit data is simply memory data.
  logic [31:0] mem     [int unsigned];
  logic [31:0] line_of [int unsigned];
  int          m_hits = 0;
  int          m_miss = 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic int unsigned line_idx(input logic [31:0] a);
    return (a / (WORDS * 4)) % LINES;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    logic [31:0] la;
    la = a & ~32'(WORDS * 4 - 1);
    return line_of.exists(line_idx(a)) && (line_of[line_idx(a)] == la);
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic idle_and_check_counters(input string tag);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (hitCount !== 16'(m_hits)) begin
      n_err++; $display("FAIL %s hitCount got=%0d exp=%0d", tag, hitCount, m_hits);
    end
    n_cmp++;
    if (missCount !== 16'(m_miss)) begin
      n_err++; $display("FAIL %s missCount got=%0d exp=%0d", tag, missCount, m_miss);
    end
    @(posedge clk); #1;
  endtask

  // Read transaction; flush_beat>=0 pulses flush during that fill beat.
  task automatic do_read(input logic [31:0] a, input int lat, input int flush_beat,
                         input bit flush_now);
    logic [31:0] la, wa;
    bit exp_hit;
    la = a & ~32'(WORDS * 4 - 1);
    wa = a & ~32'd3;
    exp_hit = model_hit(a);
    MemRead = 1'b1; MemWrite = 1'b0; memAddr = a; flush = flush_now;
    @(negedge clk);
    n_cmp++;
    if (MemHit !== exp_hit || stall !== !exp_hit) begin
      n_err++; $display("FAIL rd_lookup a=%h hit=%b stall=%b exp_hit=%b", a, MemHit, stall, exp_hit);
    end
    if (exp_hit) begin
      n_cmp++;
      if (MemReadDone !== 1'b1 || memReadData !== memval(wa) || busReq !== 1'b0) begin
        n_err++; $display("FAIL rd_hit a=%h done=%b data=%h exp=%h busReq=%b",
                          a, MemReadDone, memReadData, memval(wa), busReq);
      end
    end
    @(posedge clk); #1;
    flush = 1'b0;
    if (flush_now) line_of.delete();
    if (exp_hit) begin
      m_hits = sat(m_hits + 1);
    end else begin
      m_miss = sat(m_miss + 1);
      for (int b = 0; b < WORDS; b++) begin
        for (int w = 0; w < lat; w++) begin
          MemReadReady = (w == lat - 1);
          busRData = memval(la + 32'(b * 4));
          flush = (b == flush_beat) && (w == 0);
          @(negedge clk);
          n_cmp++;
          if (busReq !== 1'b1 || busWe !== 1'b0 || busAddr !== la + 32'(b * 4) || stall !== 1'b1) begin
            n_err++; $display("FAIL fill a=%h beat=%0d req=%b we=%b addr=%h exp=%h stall=%b",
                              a, b, busReq, busWe, busAddr, la + 32'(b * 4), stall);
          end
          @(posedge clk); #1;
        end
      end
      MemReadReady = 1'b0; flush = 1'b0; busRData = '0;
      @(negedge clk);
      n_cmp++;
      if (MemReadDone !== 1'b1 || MemHit !== 1'b0 || memReadData !== memval(wa) ||
          stall !== 1'b0 || busReq !== 1'b0) begin
        n_err++; $display("FAIL rd_done a=%h done=%b hit=%b data=%h exp=%h stall=%b req=%b",
                          a, MemReadDone, MemHit, memReadData, memval(wa), stall, busReq);
      end
      @(posedge clk); #1;
      line_of[line_idx(a)] = la;
      if (flush_beat >= 0) line_of.delete();
    end
    MemRead = 1'b0;
    idle_and_check_counters("rd");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat,
                          input bit also_read);
    logic [31:0] wa;
    wa = a & ~32'd3;
    MemWrite = 1'b1; MemRead = also_read; memAddr = a; memWriteData = d;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1 || busReq !== 1'b0 || MemReadDone !== 1'b0 || MemHit !== 1'b0) begin
      n_err++; $display("FAIL wr_req a=%h stall=%b req=%b done=%b hit=%b",
                        a, stall, busReq, MemReadDone, MemHit);
    end
    @(posedge clk); #1;
    for (int w = 0; w < lat; w++) begin
      MemReadReady = (w == lat - 1);
      @(negedge clk);
      n_cmp++;
      if (busReq !== 1'b1 || busWe !== 1'b1 || busAddr !== wa || busWData !== d ||
          stall !== (w != lat - 1)) begin
        n_err++; $display("FAIL wr_bus a=%h cyc=%0d req=%b we=%b addr=%h data=%h stall=%b",
                          a, w, busReq, busWe, busAddr, busWData, stall);
      end
      @(posedge clk); #1;
    end
    MemReadReady = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    mem[wa] = d;
    idle_and_check_counters("wr");
  endtask

  task automatic test_reset;
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; flush = 1'b0; MemReadReady = 1'b0;
    memAddr = '0; memWriteData = '0; busRData = '0;
    #3;
    n_cmp++;
    if (stall !== 1'b0 || busReq !== 1'b0 || busWe !== 1'b0 || MemReadDone !== 1'b0 ||
        MemHit !== 1'b0 || memReadData !== 32'd0 || hitCount !== 16'd0 || missCount !== 16'd0) begin
      n_err++; $display("FAIL reset_state stall=%b req=%b we=%b done=%b hit=%b data=%h hc=%0d mc=%0d",
                        stall, busReq, busWe, MemReadDone, MemHit, memReadData, hitCount, missCount);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_read;
    do_read(32'h100, 1, -1, 1'b0);
    n_cmp++;
    if (missCount !== 16'd1) begin
      n_err++; $display("FAIL cold_miss_count got=%0d exp=1", missCount);
    end
  endtask

  task automatic test_warm_read;
    do_read(32'h108, 1, -1, 1'b0);
    n_cmp++;
    if (hitCount !== 16'd1) begin
      n_err++; $display("FAIL warm_hit_count got=%0d exp=1", hitCount);
    end
  endtask

  task automatic test_write_hit;
    do_write(32'h104, 32'hDEAD_BEEF, 3, 1'b0);
    do_read(32'h104, 1, -1, 1'b0);
  endtask

  task automatic test_conflict;
    do_read(32'h100, 1, -1, 1'b0);
    do_read(32'h500, 2, -1, 1'b0);
    do_read(32'h100, 1, -1, 1'b0);
  endtask

  task automatic test_flush_fill;
    do_read(32'h208, 1, 1, 1'b0);
    do_read(32'h208, 1, -1, 1'b0);
  endtask

  task automatic test_flush_idle;
    do_read(32'h20C, 1, -1, 1'b1);
    do_read(32'h20C, 1, -1, 1'b0);
  endtask

  task automatic test_write_miss;
    do_write(32'h624, 32'h1357_9BDF, 2, 1'b0);
    do_read(32'h624, 1, -1, 1'b0);
  endtask

  task automatic test_read_write_both;
    do_write(32'h628, 32'hCAFE_F00D, 1, 1'b1);
    do_read(32'h628, 1, -1, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      int r;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 6)
        do_read(a, $urandom_range(1, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1, 1'b0);
      else if (r < 9)
        do_write(a, $urandom, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      else
        do_read(a, 1, -1, 1'b1);
    end
  endtask

  task automatic test_reset_mid_fill;
    logic [31:0] a;
    a = 32'h340;
    line_of.delete(line_idx(a));
    do_read(32'h000, 1, -1, 1'b1);
    MemRead = 1'b1; memAddr = a;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      MemReadReady = 1'b1; busRData = memval(a + 32'(b * 4));
      @(posedge clk); #1;
    end
    MemReadReady = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busReq !== 1'b1 || busAddr !== a + 32'd8) begin
      n_err++; $display("FAIL pre_reset_fill req=%b addr=%h exp=%h", busReq, busAddr, a + 32'd8);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || busReq !== 1'b0 || busWe !== 1'b0 || MemReadDone !== 1'b0 ||
        MemHit !== 1'b0 || memReadData !== 32'd0 || hitCount !== 16'd0 || missCount !== 16'd0) begin
      n_err++; $display("FAIL async_reset stall=%b req=%b we=%b done=%b hit=%b data=%h hc=%0d mc=%0d",
                        stall, busReq, busWe, MemReadDone, MemHit, memReadData, hitCount, missCount);
    end
    @(posedge clk); #1;
    reset = 1'b1; MemRead = 1'b0;
    line_of.delete(); m_hits = 0; m_miss = 0;
    @(posedge clk); #1;
    do_read(a, 1, -1, 1'b0);
  endtask

  task automatic test_saturation;
    MemRead = 1'b1; memAddr = 32'h344;
    repeat (65540) @(posedge clk);
    #1 MemRead = 1'b0;
    m_hits = sat(m_hits + 65540);
    @(posedge clk); #1;
    n_cmp++;
    if (hitCount !== 16'hFFFF) begin
      n_err++; $display("FAIL hit_saturate got=%h exp=ffff", hitCount);
    end
    do_read(32'h348, 1, -1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_cold_read;
    test_warm_read;
    test_write_hit;
    test_conflict;
    test_flush_fill;
    test_flush_idle;
    test_write_miss;
    test_read_write_both;
    test_random;
    test_reset_mid_fill;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
